// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the single-port memory arbiter.
// Used by mem_arbiter and anything that needs to name its states or owner.
package mem_arb_pkg;

    localparam int ADDR_W_DEF   = 32;
    localparam int DATA_W_DEF   = 32;
    localparam int FAIR_MAX_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } arb_owner_t;

    // Bits needed to count data grants up to fair_max (at least one bit).
    function automatic int streak_width(input int fair_max);
        if (fair_max < 2) begin
            return 1;
        end else begin
            return $clog2(fair_max + 1);
        end
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for one shared memory port: one outstanding transaction,
// registered request fields, registered per-requester response pulses.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int FAIR_MAX = FAIR_MAX_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ifReq,
    input  logic [ADDR_W-1:0]     ifAddr,
    input  logic                  flushF,
    output logic                  ifValid,
    output logic [DATA_W-1:0]     ifRdata,
    input  logic                  dReq,
    input  logic                  dWe,
    input  logic [ADDR_W-1:0]     dAddr,
    input  logic [DATA_W-1:0]     dWdata,
    input  logic [DATA_W/8-1:0]   dWstrb,
    output logic                  dValid,
    output logic [DATA_W-1:0]     dRdata,
    output logic                  stallF,
    output logic                  stallM,
    output logic                  memReq,
    output logic                  memWe,
    output logic [ADDR_W-1:0]     memAddr,
    output logic [DATA_W-1:0]     memWdata,
    output logic [DATA_W/8-1:0]   memWstrb,
    input  logic                  memReady,
    input  logic                  memRvalid,
    input  logic [DATA_W-1:0]     memRdata
);

    localparam int STREAK_W = streak_width(FAIR_MAX);
    localparam logic [STREAK_W-1:0] FAIR_CAP = STREAK_W'(FAIR_MAX);

    arb_state_t             state_q, state_d;
    arb_owner_t             owner_q, owner_d;
    logic                   kill_q, kill_d;
    logic [STREAK_W-1:0]    streak_q, streak_d;
    logic                   mem_req_q, mem_req_d;
    logic                   mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;
    logic [DATA_W/8-1:0]    mem_wstrb_q, mem_wstrb_d;
    logic                   if_valid_q, if_valid_d;
    logic                   d_valid_q, d_valid_d;
    logic [DATA_W-1:0]      if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]      d_rdata_q, d_rdata_d;
    logic                   grant_fetch_s;
    logic                   grant_data_s;
    logic                   fetch_forced_s;
    logic                   flush_hit_s;

    assign fetch_forced_s = (FAIR_MAX != 0) && (streak_q == FAIR_CAP);
    assign grant_fetch_s  = ifReq && (!dReq || fetch_forced_s);
    assign grant_data_s   = dReq && !grant_fetch_s;
    assign flush_hit_s    = flushF && (owner_q == OWN_FETCH);

    // Next-state, grant, fairness and response-capture logic.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        kill_d      = kill_q;
        streak_d    = streak_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        if_valid_d  = 1'b0;
        d_valid_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;

        case (state_q)
            IDLE: begin
                kill_d = 1'b0;
                if (grant_fetch_s) begin
                    owner_d     = OWN_FETCH;
                    streak_d    = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = ifAddr;
                    mem_wdata_d = '0;
                    mem_wstrb_d = '0;
                    state_d     = ISSUE;
                end else if (grant_data_s) begin
                    owner_d     = OWN_DATA;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dWe;
                    mem_addr_d  = dAddr;
                    mem_wdata_d = dWdata;
                    mem_wstrb_d = dWstrb;
                    state_d     = ISSUE;
                    // Only data grants that made fetch wait count toward fairness.
                    if (!ifReq) begin
                        streak_d = '0;
                    end else if (streak_q != FAIR_CAP) begin
                        streak_d = streak_q + STREAK_W'(1);
                    end else begin
                        streak_d = streak_q;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                kill_d = kill_q | flush_hit_s;
                if (memReady) begin
                    mem_req_d = 1'b0;
                    state_d   = WAIT;
                end else begin
                    state_d   = ISSUE;
                end
            end
            WAIT: begin
                kill_d = kill_q | flush_hit_s;
                if (memRvalid) begin
                    state_d = DONE;
                    if (owner_q == OWN_FETCH) begin
                        if_rdata_d = memRdata;
                        if_valid_d = !(kill_q || flushF);
                    end else begin
                        d_rdata_d  = memRdata;
                        d_valid_d  = 1'b1;
                    end
                end else begin
                    state_d = WAIT;
                end
            end
            DONE: begin
                kill_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                kill_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= OWN_FETCH;
            kill_q      <= 1'b0;
            streak_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            kill_q      <= kill_d;
            streak_q    <= streak_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            if_valid_q  <= if_valid_d;
            d_valid_q   <= d_valid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign memReq   = mem_req_q;
    assign memWe    = mem_we_q;
    assign memAddr  = mem_addr_q;
    assign memWdata = mem_wdata_q;
    assign memWstrb = mem_wstrb_q;
    assign ifValid  = if_valid_q;
    assign dValid   = d_valid_q;
    assign ifRdata  = if_rdata_q;
    assign dRdata   = d_rdata_q;
    assign stallF   = ifReq & ~if_valid_q;
    assign stallM   = dReq & ~d_valid_q;

endmodule
